ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite slave with a word-organised internal SRAM. It sits directly downstream of the Wishbone-to-AHB master bridge and consumes its HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA. It supports byte, halfword and word accesses with a configurable number of wait states. Illegal transfers receive the two-cycle AHB ERROR response.

Parameters:
ADDR_WIDTH, 12, byte-address bits decoded; memory holds 2^(ADDR_WIDTH-2) 32-bit words.
WAIT_STATES, 1, wait cycles inserted per valid transfer; legal range 0..7.

Ports:
HCLK  input  1  clock
HRESETn  input  1  reset, asynchronous, active-low
HSEL  input  1  slave select
HADDR  input  32  byte address; only [ADDR_WIDTH-1:0] are used
HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
HWRITE  input  1  1 = write
HSIZE  input  3  000 = byte, 001 = halfword, 010 = word
HBURST  input  3  ignored
HWDATA  input  32  write data, valid in the data phase
HREADY  input  1  bus ready (combined HREADY)
HREADYOUT  output  1  slave ready
HRESP  output  1  0 = OKAY, 1 = ERROR
HRDATA  output  32  read data

Behaviour:
- Clock and reset: HCLK clocks the block; HRESETn is the asynchronous, active-low reset.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, all captured address-phase registers=0. SRAM contents are not reset.
- Address phase accept: occurs when HSEL & HREADY & HTRANS[1]. On the rising edge the block registers addr_q=HADDR[ADDR_WIDTH-1:0], write_q, size_q.
  - SEQ is treated as NONSEQ; the address always comes from HADDR.
  - IDLE/BUSY transfers, or HSEL=0: no transfer is accepted. The block returns zero-wait OKAY.
- Validity check at accept:
  - Illegal if HSIZE>010.
  - Illegal if size=001 with HADDR[0]=1.
  - Illegal if size=010 with HADDR[1:0]!=00.
- State machine (IDLE, WAIT, LAST, ERR1, ERR2):
  - IDLE: HREADYOUT=1, HRESP=0. On accept:
    - illegal -> ERR1;
    - legal with WAIT_STATES=0 -> LAST;
    - legal otherwise -> WAIT, cnt=WAIT_STATES-1.
  - WAIT: HREADYOUT=0, HRESP=0. If cnt==0 -> LAST, else cnt decrements.
  - LAST: HREADYOUT=1, HRESP=0. The data phase completes this cycle. A new accept in this cycle is pipelined with the same decode as from IDLE; with no accept -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. A new accept is honoured as in IDLE; with no accept -> IDLE.
- Write commit: occurs at the rising edge ending LAST (write_q=1).
  - Byte lanes are enabled per size_q/addr_q[1:0], little-endian. Byte n uses HWDATA[8n+7:8n]; a halfword uses lanes {1,0} or {3,2}.
  - Word index = addr_q[ADDR_WIDTH-1:2].
  - Addresses beyond the memory alias; the upper HADDR bits are ignored.
- Read data:
  - HRDATA = full 32-bit word mem[addr_q[ADDR_WIDTH-1:2]] during LAST with write_q=0; otherwise 0.
  - No lane masking; the master selects the lanes.
  - Memory read is combinational from the registered index.
  - A read immediately after a write to the same word returns the new data.
- The data phase is independent of HSEL: a data phase in progress completes even if HSEL drops.
- An address phase presented while HREADY=0 is not accepted; the master holds it.
- Reset asserted mid-transfer aborts it: no write is committed, and outputs return to reset values immediately.

Test Plan:
- WAIT_STATES=1: NONSEQ word write 0xDEADBEEF @0x010, then read @0x010 -> write: HREADYOUT low 1 cycle then high; read returns HRDATA=0xDEADBEEF in its LAST cycle, HRESP=0.
- WAIT_STATES=0: byte write 0xAA on lane 2 @0x012 over word 0x11223344 @0x010, then read @0x010 -> HRDATA=0x11AA3344.
- Halfword write @0x021 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); a subsequent read @0x020 shows unchanged memory.
- WAIT_STATES=3: back-to-back NONSEQ reads @0x000, @0x004 with the second address phase held during waits -> each transfer has exactly 3 low HREADYOUT cycles, then correct data, with no lost or duplicated transfer.
- IDLE and BUSY cycles with HSEL=1 -> HREADYOUT=1, HRESP=0, HRDATA=0, no state change.
- HRESETn pulsed low during WAIT of a write of 0x55555555 @0x030 -> HREADYOUT=1 and state IDLE immediately; a later read @0x030 returns the pre-reset value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_slave
//  Description : AHB-Lite slave in front of a word-organised internal SRAM.
//                Byte, halfword and word accesses are supported, with a fixed
//                number of wait states inserted per valid transfer.
//                Misaligned or oversized transfers receive the two-cycle
//                ERROR response and never touch the memory.
//  Ports       : HCLK, HRESETn        clock, async active-low reset
//                HSEL/HADDR/HTRANS/   address-phase inputs (HBURST ignored)
//                HWRITE/HSIZE/HBURST
//                HWDATA               write data, sampled in the data phase
//                HREADY               combined bus ready
//                HREADYOUT/HRESP      slave ready and response
//                HRDATA               read data (zero outside read completion)
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         c_DEPTH  = 2 ** (ADDR_WIDTH - 2);
    localparam logic [2:0] c_WS_M1  = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_LAST = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [31:0]           r_mem [c_DEPTH];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_commit;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-3:0] w_idx;
    logic                  w_unused;

    // Bits of the bus that carry no meaning for this slave.
    assign w_unused = ^{HBURST, HADDR[31:ADDR_WIDTH], HTRANS[0]};

    // Ready is low only while a transfer is being stretched (wait states or
    // the first error cycle); it is a pure decode of the state register.
    assign w_ready   = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign HREADYOUT = w_ready;
    assign HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);

    // SEQ is handled exactly like NONSEQ: HTRANS[1] marks an active transfer.
    // Gating with our own ready keeps a stretched data phase from being
    // overwritten if the combined HREADY were ever high during it.
    assign w_accept = HSEL && HREADY && HTRANS[1] && w_ready;

    always_comb begin
        w_legal = 1'b0;
        case (HSIZE)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~HADDR[0];
            3'b010:  w_legal = (HADDR[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state logic. IDLE, LAST and ERR2 all sit at HREADYOUT=1 and so
    // share the same address-phase decode, which gives pipelined back-to-back
    // transfers for free.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_LAST;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_WS_M1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = ST_LAST;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_ERR1: begin
                w_state_nxt = ST_ERR2;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= HADDR[ADDR_WIDTH-1:0];
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    // Little-endian lane selection. Only legal transfers ever reach LAST, so
    // the captured size/alignment here is always consistent.
    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            3'b000:  w_be = 4'b0001 << r_addr[1:0];
            3'b001:  w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    assign w_idx    = r_addr[ADDR_WIDTH-1:2];
    // An asynchronous reset forces IDLE at once, so an interrupted write can
    // never reach its commit edge.
    assign w_commit = (r_state == ST_LAST) && r_write;

    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Full word is returned; the master picks its own lanes.
    assign HRDATA = ((r_state == ST_LAST) && !r_write) ? r_mem[w_idx] : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_sram_slave
//  Description : Scoreboard bench for ahb_sram_slave. Three instances with
//                WAIT_STATES of 0, 1 and 3 each get their own master driver,
//                reference memory model and bus monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    typedef struct packed {
        logic        rd;
        logic        ill;
        logic [31:0] data;
    } exp_t;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rst_n  [3];
    logic        hsel   [3];
    logic [31:0] haddr  [3];
    logic [1:0]  htrans [3];
    logic        hwrite [3];
    logic [2:0]  hsize  [3];
    logic [2:0]  hburst [3];
    logic [31:0] hwdata [3];
    logic        hro    [3];
    logic        hresp  [3];
    logic [31:0] hrdata [3];

    exp_t        expq   [3][$];
    logic [31:0] mem_m  [3][1024];
    int          n_checks = 0;
    int          n_fail   = 0;

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
        .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]),
        .HWDATA(hwdata[0]), .HREADY(hro[0]), .HREADYOUT(hro[0]), .HRESP(hresp[0]),
        .HRDATA(hrdata[0]));

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(1)) u_dut1 (
        .HCLK(HCLK), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
        .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]),
        .HWDATA(hwdata[1]), .HREADY(hro[1]), .HREADYOUT(hro[1]), .HRESP(hresp[1]),
        .HRDATA(hrdata[1]));

    ahb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) u_dut2 (
        .HCLK(HCLK), .HRESETn(rst_n[2]), .HSEL(hsel[2]), .HADDR(haddr[2]),
        .HTRANS(htrans[2]), .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HBURST(hburst[2]),
        .HWDATA(hwdata[2]), .HREADY(hro[2]), .HREADYOUT(hro[2]), .HRESP(hresp[2]),
        .HRDATA(hrdata[2]));

    function automatic int ws_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(int k, string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", k, name, act, exp, $time);
        end
    endtask

    // Wait for the edge at which the slave is ready; that edge accepts the
    // address phase on the bus and completes any outstanding data phase.
    task automatic wait_ready(int k);
        logic r;
        int   guard;
        r     = 1'b0;
        guard = 0;
        while (!r && guard < 64) begin
            @(negedge HCLK);
            r = hro[k];
            @(posedge HCLK);
            guard++;
        end
        #1;
        if (!r) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d ready_timeout: HREADYOUT stayed 0 for %0d cycles, expected 1", k, guard);
        end
    endtask

    // Reference model: bytes are written lane by lane from the address
    // offset; words alias on the low 12 address bits.
    task automatic issue(int k, logic wr, logic [31:0] a, logic [2:0] sz,
                         logic [31:0] d, logic push);
        exp_t e;
        int   idx, nb, lane;
        logic legal;
        hsel[k]   = 1'b1;
        haddr[k]  = a;
        htrans[k] = {1'b1, 1'($urandom)};
        hwrite[k] = wr;
        hsize[k]  = sz;
        hburst[k] = 3'($urandom);
        wait_ready(k);
        hwdata[k] = wr ? d : $urandom;
        if (push) begin
            idx   = int'(a % 32'd4096) / 4;
            nb    = (sz <= 3'd2) ? (1 << sz) : 0;
            legal = (nb != 0) && ((a % nb) == 0);
            e     = '0;
            e.rd  = ~wr;
            if (!legal) begin
                e.ill = 1'b1;
            end else if (wr) begin
                for (int b = 0; b < nb; b++) begin
                    lane = int'(a % 4) + b;
                    mem_m[k][idx][lane*8 +: 8] = d[lane*8 +: 8];
                end
            end else begin
                e.data = mem_m[k][idx];
            end
            expq[k].push_back(e);
        end
    endtask

    task automatic idle_cycles(int k, int n);
        hsel[k]   = 1'($urandom);
        htrans[k] = {1'b0, 1'($urandom)};
        haddr[k]  = $urandom;
        hwrite[k] = 1'($urandom);
        wait_ready(k);
        hwdata[k] = $urandom;
        repeat (n) begin
            hsel[k]   = 1'($urandom);
            htrans[k] = {1'b0, 1'($urandom)};
            haddr[k]  = $urandom;
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic drive(int k);
        logic [31:0] a;
        logic [2:0]  sz;
        // Known contents for the region the random phase uses.
        for (int w = 0; w < 16; w++) issue(k, 1'b1, 32'(w * 4), 3'd2, $urandom, 1'b1);
        issue(k, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF, 1'b1);
        issue(k, 1'b0, 32'h010, 3'd2, 32'h0, 1'b1);
        issue(k, 1'b1, 32'h010, 3'd2, 32'h11223344, 1'b1);
        issue(k, 1'b1, 32'h012, 3'd0, 32'h55AA6677, 1'b1);
        issue(k, 1'b0, 32'h010, 3'd2, 32'h0, 1'b1);
        issue(k, 1'b1, 32'h021, 3'd1, 32'hCAFEF00D, 1'b1);
        issue(k, 1'b0, 32'h020, 3'd2, 32'h0, 1'b1);
        issue(k, 1'b0, 32'h000, 3'd2, 32'h0, 1'b1);
        issue(k, 1'b0, 32'h004, 3'd2, 32'h0, 1'b1);
        idle_cycles(k, 4);
        // Interrupted write: reset lands right after the address phase.
        issue(k, 1'b1, 32'h030, 3'd2, 32'h55555555, 1'b0);
        htrans[k] = 2'b00;
        rst_n[k]  = 1'b0;
        #1;
        chk(k, "async_rst_hreadyout", 32'(hro[k]), 32'd1);
        chk(k, "async_rst_hresp", 32'(hresp[k]), 32'd0);
        @(negedge HCLK);
        #1;
        rst_n[k] = 1'b1;
        @(posedge HCLK);
        #1;
        issue(k, 1'b0, 32'h030, 3'd2, 32'h0, 1'b1);
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 7) == 0) idle_cycles(k, $urandom_range(0, 3));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = {20'($urandom), 12'($urandom_range(0, 63))};
            issue(k, 1'($urandom), a, sz, $urandom, 1'b1);
        end
        idle_cycles(k, 3);
        chk(k, "queue_drained", 32'(expq[k].size()), 32'd0);
    endtask

    // Bus monitor: follows data phases purely from bus activity and checks
    // each completion against the oldest expected response.
    task automatic monitor(int k);
        logic        pend = 1'b0;
        logic        errf = 1'b0;
        int          waits = 0;
        exp_t        e;
        logic        ro, rs;
        logic [31:0] rd;
        forever begin
            @(negedge HCLK);
            ro = hro[k];
            rs = hresp[k];
            rd = hrdata[k];
            if (!rst_n[k]) begin
                pend = 1'b0;
                chk(k, "reset_hreadyout", 32'(ro), 32'd1);
                chk(k, "reset_hresp", 32'(rs), 32'd0);
                chk(k, "reset_hrdata", rd, 32'd0);
            end else begin
                if (!pend) begin
                    chk(k, "idle_hreadyout", 32'(ro), 32'd1);
                    chk(k, "idle_hresp", 32'(rs), 32'd0);
                    chk(k, "idle_hrdata", rd, 32'd0);
                end else if (rs && !ro) begin
                    chk(k, "err_without_wait", 32'(waits), 32'd0);
                    errf = 1'b1;
                end else if (!ro) begin
                    waits++;
                    chk(k, "hrdata_zero_in_wait", rd, 32'd0);
                end else if (expq[k].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut%0d unexpected_response: got hresp=%0d, expected no transfer", k, rs);
                    pend = 1'b0;
                end else begin
                    e = expq[k].pop_front();
                    pend = 1'b0;
                    if (rs) begin
                        chk(k, "error_first_cycle_seen", 32'(errf), 32'd1);
                        chk(k, "error_response_expected", 32'(e.ill), 32'd1);
                    end else begin
                        chk(k, "okay_response_expected", 32'(e.ill), 32'd0);
                        chk(k, "wait_state_count", 32'(waits), 32'(ws_of(k)));
                        chk(k, e.rd ? "read_data" : "write_hrdata_zero", rd, e.rd ? e.data : 32'd0);
                    end
                end
                if (hsel[k] && hro[k] && htrans[k][1]) begin
                    pend  = 1'b1;
                    waits = 0;
                    errf  = 1'b0;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k]  = 1'b0;
            hsel[k]   = 1'b0;
            haddr[k]  = 32'h0;
            htrans[k] = 2'b00;
            hwrite[k] = 1'b0;
            hsize[k]  = 3'd0;
            hburst[k] = 3'd0;
            hwdata[k] = 32'h0;
        end
        repeat (2) @(negedge HCLK);
        #1;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        @(posedge HCLK);
        #1;
        fork
            drive(0);
            drive(1);
            drive(2);
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached before test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
